// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scan controller.
// Scans DIGITS common-enable digits from a packed nibble bus with per-digit
// decimal point, enable and blink, optional leading-zero blanking, and a
// double-buffered display image that only changes at frame boundaries.
module seg7_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 20000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 312
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_on,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lzb,
    input  logic                  load,
    output logic [DIGITS-1:0]     led_en,
    output logic [7:0]            led_seg,
    output logic                  frame_done
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0]       div;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       fcnt;
    logic                phase;

    logic [4*DIGITS-1:0] stg_data;
    logic [DIGITS-1:0]   stg_dp;
    logic [DIGITS-1:0]   stg_on;
    logic [DIGITS-1:0]   stg_blink;
    logic                stg_lzb;
    logic                pending;

    logic [4*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_on;
    logic [DIGITS-1:0]   act_blink;
    logic                act_lzb;

    logic                div_tc;
    logic                wrap;
    logic                in_blank;
    logic                visible;
    logic [3:0]          cur_val;
    logic [DIGITS-1:0]   lz_mask;
    logic                leading;

    // Active-low segment pattern {g,f,e,d,c,b,a}; lowercase b and d.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign div_tc     = (div == DIV_LAST);
    assign wrap       = div_tc && (idx == IDX_LAST);
    assign frame_done = wrap;

    // Slot decode and leading-zero mask derived from the active image.
    always_comb begin
        in_blank = (div < BLANK_END);
        visible  = act_on[idx] & ~(act_blink[idx] & phase);
        cur_val  = act_data[{idx, 2'b00} +: 4];
        lz_mask  = '0;
        leading  = 1'b1;
        if (act_lzb) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (act_on[i]) begin
                    if (act_data[4*i +: 4] == 4'h0) begin
                        if (leading) lz_mask[i] = 1'b1;
                    end else begin
                        leading = 1'b0;
                    end
                end
            end
        end
    end

    // Slot timing: divider holds each digit for SCAN_DIV cycles, then index advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (div_tc) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            div <= div + DW'(1);
        end
    end

    // Blink phase toggles after every BLINK_FRAMES complete frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FRM_LAST) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Double buffer: loads land in staging and are promoted only at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            stg_on    <= '0;
            stg_blink <= '0;
            stg_lzb   <= 1'b0;
            pending   <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_on    <= '0;
            act_blink <= '0;
            act_lzb   <= 1'b0;
        end else if (load) begin
            stg_data  <= data;
            stg_dp    <= dp;
            stg_on    <= digit_on;
            stg_blink <= blink;
            stg_lzb   <= lzb;
            if (wrap) begin
                act_data  <= data;
                act_dp    <= dp;
                act_on    <= digit_on;
                act_blink <= blink;
                act_lzb   <= lzb;
                pending   <= 1'b0;
            end else begin
                pending <= 1'b1;
            end
        end else if (wrap && pending) begin
            act_data  <= stg_data;
            act_dp    <= stg_dp;
            act_on    <= stg_on;
            act_blink <= stg_blink;
            act_lzb   <= stg_lzb;
            pending   <= 1'b0;
        end
    end

    // Registered drive: anti-ghost gap and hidden digits leave everything dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_en  <= '1;
            led_seg <= 8'hFF;
        end else if (in_blank || !visible) begin
            led_en  <= '1;
            led_seg <= 8'hFF;
        end else begin
            led_en  <= ~(DIGITS'(1) << idx);
            led_seg <= {~act_dp[idx], lz_mask[idx] ? 7'h7F : hex_glyph(cur_val)};
        end
    end

endmodule
